// File: rtl/vga_timing_pkg.sv
// Timing tables and helpers shared by the VGA timing generator and its bench-facing decode.
// Each axis is described as display/front/sync/back in pixel-clock (H) or line (V) units.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1024X768 = 2'd2,
    MODE_TEST     = 2'd3
  } vga_mode_e;

  typedef logic [11:0] tval_t;

  typedef struct packed {
    tval_t disp;
    tval_t front;
    tval_t sync;
    tval_t back;
  } axis_timing_t;

  // Decode thresholds derived from one axis: sync window is [sync_first, sync_end).
  typedef struct packed {
    tval_t disp;
    tval_t sync_first;
    tval_t sync_end;
    tval_t last;
  } axis_limits_t;

  localparam axis_timing_t H_640  = '{12'd640,  12'd16, 12'd96,  12'd48};
  localparam axis_timing_t V_480  = '{12'd480,  12'd10, 12'd2,   12'd33};
  localparam axis_timing_t H_800  = '{12'd800,  12'd40, 12'd128, 12'd88};
  localparam axis_timing_t V_600  = '{12'd600,  12'd1,  12'd4,   12'd23};
  localparam axis_timing_t H_1024 = '{12'd1024, 12'd24, 12'd136, 12'd160};
  localparam axis_timing_t V_768  = '{12'd768,  12'd3,  12'd6,   12'd29};
  localparam axis_timing_t H_TEST = '{12'd8,    12'd2,  12'd3,   12'd1};
  localparam axis_timing_t V_TEST = '{12'd4,    12'd1,  12'd1,   12'd1};

  // Bit n set means mode n uses active-high sync pulses.
  localparam logic [3:0] SYNC_POSITIVE = 4'b0010;

  function automatic axis_timing_t h_axis(input vga_mode_e m);
    case (m)
      MODE_640X480:  return H_640;
      MODE_800X600:  return H_800;
      MODE_1024X768: return H_1024;
      default:       return H_TEST;
    endcase
  endfunction

  function automatic axis_timing_t v_axis(input vga_mode_e m);
    case (m)
      MODE_640X480:  return V_480;
      MODE_800X600:  return V_600;
      MODE_1024X768: return V_768;
      default:       return V_TEST;
    endcase
  endfunction

  function automatic tval_t axis_total(input axis_timing_t a);
    return a.disp + a.front + a.sync + a.back;
  endfunction

  function automatic tval_t h_total(input vga_mode_e m);
    return axis_total(h_axis(m));
  endfunction

  function automatic tval_t v_total(input vga_mode_e m);
    return axis_total(v_axis(m));
  endfunction

  function automatic logic sync_positive(input vga_mode_e m);
    return SYNC_POSITIVE[m];
  endfunction

  function automatic axis_limits_t axis_limits(input axis_timing_t a);
    axis_limits_t l;
    l.disp       = a.disp;
    l.sync_first = a.disp + a.front;
    l.sync_end   = l.sync_first + a.sync;
    l.last       = axis_total(a) - 12'd1;
    return l;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; terminal count is supplied at run time.
// wrap is combinational so the next axis can advance on the same edge.
module vga_axis_counter #(
  parameter int W = 11
) (
  input  logic         CLK_pix_rate,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == last);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_pix_rate or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two chained axis counters, frame-boundary mode switching,
// and a single output register stage so every output describes the same pixel.
module vga_timing_gen #(
  parameter int         COUNT_W    = 11,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input  logic               CLK_pix_rate,
  input  logic               reset,
  input  logic               ce,
  input  logic [1:0]         mode,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic [COUNT_W-1:0] pixel_x,
  output logic [COUNT_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [1:0]         mode_active
);

  import vga_timing_pkg::*;

  localparam logic SYNC_IDLE = ~sync_positive(vga_mode_e'(RESET_MODE));

  vga_mode_e          mode_reg;
  axis_limits_t       h_lim, v_lim;
  logic [COUNT_W-1:0] h_cnt, v_cnt;
  logic [COUNT_W-1:0] h_last, v_last;
  logic               h_wrap, v_wrap;
  logic               h_raw, v_raw, vis;

  assign h_lim  = axis_limits(h_axis(mode_reg));
  assign v_lim  = axis_limits(v_axis(mode_reg));
  assign h_last = COUNT_W'(h_lim.last);
  assign v_last = COUNT_W'(v_lim.last);

  vga_axis_counter #(.W(COUNT_W)) u_h_cnt (
    .CLK_pix_rate (CLK_pix_rate),
    .reset        (reset),
    .en           (ce),
    .last         (h_last),
    .cnt          (h_cnt),
    .wrap         (h_wrap)
  );

  vga_axis_counter #(.W(COUNT_W)) u_v_cnt (
    .CLK_pix_rate (CLK_pix_rate),
    .reset        (reset),
    .en           (h_wrap),
    .last         (v_last),
    .cnt          (v_cnt),
    .wrap         (v_wrap)
  );

  // v_wrap marks the last pixel of the frame; the new mode owns the very next pixel.
  always_ff @(posedge CLK_pix_rate or posedge reset) begin
    if (reset) begin
      mode_reg <= vga_mode_e'(RESET_MODE);
    end else if (v_wrap) begin
      mode_reg <= vga_mode_e'(mode);
    end
  end

  always_comb begin
    h_raw = (h_cnt >= COUNT_W'(h_lim.sync_first)) && (h_cnt < COUNT_W'(h_lim.sync_end));
    v_raw = (v_cnt >= COUNT_W'(v_lim.sync_first)) && (v_cnt < COUNT_W'(v_lim.sync_end));
    vis   = (h_cnt < COUNT_W'(h_lim.disp)) && (v_cnt < COUNT_W'(v_lim.disp));
  end

  // mode_active is registered alongside the decodes so it names the mode of the pixel shown.
  always_ff @(posedge CLK_pix_rate or posedge reset) begin
    if (reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_sync      <= SYNC_IDLE;
      v_sync      <= SYNC_IDLE;
      mode_active <= RESET_MODE;
    end else if (ce) begin
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      video_on    <= vis;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      h_sync      <= sync_positive(mode_reg) ? h_raw : ~h_raw;
      v_sync      <= sync_positive(mode_reg) ? v_raw : ~v_raw;
      mode_active <= mode_reg;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a pixel-index reference model drives expectations
// for an 11-bit and a 12-bit instance running side by side.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [1:0]  mode;

  logic        hs_a, vs_a, vid_a, ls_a, fs_a;
  logic [10:0] px_a, py_a;
  logic [1:0]  ma_a;
  logic        hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [11:0] px_b, py_b;
  logic [1:0]  ma_b;

  vga_timing_gen #(.COUNT_W(11), .RESET_MODE(2'd3)) dut (
    .CLK_pix_rate (clk), .reset (reset), .ce (ce), .mode (mode),
    .h_sync (hs_a), .v_sync (vs_a), .video_on (vid_a),
    .pixel_x (px_a), .pixel_y (py_a),
    .line_start (ls_a), .frame_start (fs_a), .mode_active (ma_a)
  );

  vga_timing_gen #(.COUNT_W(12), .RESET_MODE(2'd3)) dut12 (
    .CLK_pix_rate (clk), .reset (reset), .ce (ce), .mode (mode),
    .h_sync (hs_b), .v_sync (vs_b), .video_on (vid_b),
    .pixel_x (px_b), .pixel_y (py_b),
    .line_start (ls_b), .frame_start (fs_b), .mode_active (ma_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Timing table as plain numbers, indexed by mode.
  int HD[4] = '{640, 800, 1024, 8};
  int HF[4] = '{16, 40, 24, 2};
  int HS[4] = '{96, 128, 136, 3};
  int HB[4] = '{48, 88, 160, 1};
  int VD[4] = '{480, 600, 768, 4};
  int VF[4] = '{10, 1, 3, 1};
  int VS[4] = '{2, 4, 6, 1};
  int VB[4] = '{33, 23, 29, 1};
  bit POS[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Model: current mode and linear pixel index within the frame.
  int   m_mode, m_n;
  int   e_x, e_y, e_mode;
  logic e_vid, e_hs, e_vs, e_ls, e_fs;

  int st_vid, st_hact, st_vact, st_fs, st_hmin, st_hmax, st_vmin, st_vmax;

  function automatic int htot(input int m);
    return HD[m] + HF[m] + HS[m] + HB[m];
  endfunction

  function automatic int vtot(input int m);
    return VD[m] + VF[m] + VS[m] + VB[m];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 3; m_n = 0;
    e_x = 0; e_y = 0; e_vid = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    e_hs = 1'b1; e_vs = 1'b1; e_mode = 3;
  endtask

  task automatic model_step();
    int x, y;
    logic hr, vr;
    x = m_n % htot(m_mode);
    y = m_n / htot(m_mode);
    hr = (x >= HD[m_mode] + HF[m_mode]) && (x < HD[m_mode] + HF[m_mode] + HS[m_mode]);
    vr = (y >= VD[m_mode] + VF[m_mode]) && (y < VD[m_mode] + VF[m_mode] + VS[m_mode]);
    e_x = x; e_y = y; e_mode = m_mode;
    e_vid = (x < HD[m_mode]) && (y < VD[m_mode]);
    e_hs = POS[m_mode] ? hr : ~hr;
    e_vs = POS[m_mode] ? vr : ~vr;
    e_ls = (x == 0);
    e_fs = (m_n == 0);
    m_n++;
    if (m_n == htot(m_mode) * vtot(m_mode)) begin
      m_n = 0;
      m_mode = int'(mode);
    end
  endtask

  task automatic check_all();
    check("px",    32'(px_a),  32'(e_x));
    check("py",    32'(py_a),  32'(e_y));
    check("vid",   32'(vid_a), 32'(e_vid));
    check("hs",    32'(hs_a),  32'(e_hs));
    check("vs",    32'(vs_a),  32'(e_vs));
    check("ls",    32'(ls_a),  32'(e_ls));
    check("fs",    32'(fs_a),  32'(e_fs));
    check("mode",  32'(ma_a),  32'(e_mode));
    check("px12",  32'(px_b),  32'(e_x));
    check("py12",  32'(py_b),  32'(e_y));
    check("vid12", 32'(vid_b), 32'(e_vid));
    check("hs12",  32'(hs_b),  32'(e_hs));
    check("vs12",  32'(vs_b),  32'(e_vs));
    check("fs12",  32'(fs_b),  32'(e_fs));
    check("mode12", 32'(ma_b), 32'(e_mode));
  endtask

  task automatic stats_reset();
    st_vid = 0; st_hact = 0; st_vact = 0; st_fs = 0;
    st_hmin = 99999; st_hmax = -1; st_vmin = 99999; st_vmax = -1;
  endtask

  // One clock: drive ce, advance the model on ce edges, check on the falling edge.
  task automatic tick(input logic c);
    ce = c;
    @(posedge clk);
    if (c) model_step();
    @(negedge clk);
    check_all();
    if (c) begin
      if (vid_a) st_vid++;
      if (fs_a) st_fs++;
      if (hs_a === POS[e_mode]) begin
        st_hact++;
        if (int'(px_a) < st_hmin) st_hmin = int'(px_a);
        if (int'(px_a) > st_hmax) st_hmax = int'(px_a);
      end
      if (vs_a === POS[e_mode]) begin
        st_vact++;
        if (int'(py_a) < st_vmin) st_vmin = int'(py_a);
        if (int'(py_a) > st_vmax) st_vmax = int'(py_a);
      end
    end
  endtask

  // Run until the counters (not yet the outputs) sit at (x, y).
  task automatic run_to(input int x, input int y, input string tag);
    int g = 0;
    while (m_n != y * htot(m_mode) + x && g < 2000) begin
      tick(1'b1);
      g++;
    end
    check(tag, 32'(g < 2000), 32'd1);
  endtask

  // Run until the requested mode has been committed and its pixel (0,0) is next.
  task automatic run_to_mode(input int m, input string tag);
    int g = 0;
    while (!(m_mode == m && m_n == 0) && g < 2000) begin
      tick(1'b1);
      g++;
    end
    check(tag, 32'(g < 2000), 32'd1);
  endtask

  // Asynchronous reset placed between clock edges; outputs must change without an edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check({tag, "_px"}, 32'(px_a), 32'd0);
    check({tag, "_hs"}, 32'(hs_a), 32'd1);
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; mode = 2'd3;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Test mode, ce held high: first frame statistics.
    stats_reset();
    repeat (98) tick(1'b1);
    check("t_vid_cnt", 32'(st_vid), 32'd32);
    check("t_hs_cnt",  32'(st_hact), 32'd21);
    check("t_hs_min",  32'(st_hmin), 32'd10);
    check("t_hs_max",  32'(st_hmax), 32'd12);
    check("t_vs_cnt",  32'(st_vact), 32'd14);
    check("t_vs_row",  32'(st_vmin), 32'd5);
    check("t_vs_row2", 32'(st_vmax), 32'd5);
    check("t_fs_cnt",  32'(st_fs), 32'd1);
    tick(1'b1);
    check("t_period_fs", 32'(fs_a), 32'd1);

    // Pseudo-random ce gaps must neither skip nor repeat pixels.
    repeat (400) tick(1'(($urandom & 32'h3) != 0));
    repeat (50) tick(1'(($urandom_range(0, 1))));

    // Same-value request and a toggle that returns before frame end: no change.
    run_to(2, 1, "run_to_21");
    mode = 2'd1;
    repeat (10) tick(1'b1);
    mode = 2'd3;
    repeat (150) tick(1'b1);
    check("toggle_mode", 32'(ma_a), 32'd3);

    // Switch to mode 1 at pixel (3,2).
    run_to(3, 2, "run_to_32");
    mode = 2'd1;
    run_to_mode(1, "enter_m1");
    check("m1_prev_x", 32'(px_a), 32'd13);
    check("m1_prev_y", 32'(py_a), 32'd6);
    check("m1_prev_mode", 32'(ma_a), 32'd3);
    stats_reset();
    tick(1'b1);
    check("m1_first_fs", 32'(fs_a), 32'd1);
    check("m1_first_mode", 32'(ma_a), 32'd1);
    repeat (1055) tick(1'b1);
    check("m1_hs_cnt", 32'(st_hact), 32'd128);
    check("m1_hs_min", 32'(st_hmin), 32'd840);
    check("m1_hs_max", 32'(st_hmax), 32'd967);

    // Mode 2: one full line after a reset-based exit from the long mode-1 frame.
    async_reset("rst_m1");
    mode = 2'd2;
    run_to_mode(2, "enter_m2");
    stats_reset();
    repeat (1344) tick(1'b1);
    check("m2_hs_cnt", 32'(st_hact), 32'd136);
    check("m2_hs_min", 32'(st_hmin), 32'd1048);
    check("m2_hs_max", 32'(st_hmax), 32'd1183);

    // Mode 0: first line, then reset mid-frame (kept to line 1 for run length).
    async_reset("rst_m2");
    mode = 2'd0;
    run_to_mode(0, "enter_m0");
    stats_reset();
    repeat (800) tick(1'b1);
    check("m0_hs_cnt", 32'(st_hact), 32'd96);
    check("m0_hs_min", 32'(st_hmin), 32'd656);
    check("m0_hs_max", 32'(st_hmax), 32'd751);
    check("m0_vid_cnt", 32'(st_vid), 32'd640);
    run_to(500, 1, "run_to_500");
    tick(1'b1);
    check("m0_pre_rst_x", 32'(px_a), 32'd500);
    async_reset("rst_m0");
    tick(1'b1);
    check("post_rst_fs", 32'(fs_a), 32'd1);
    check("post_rst_vid", 32'(vid_a), 32'd1);
    repeat (20) tick(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter COUNT_W, default 11: width of the pixel_x/pixel_y counters; SHALL be at least 11.
REQ-002 Parameter RESET_MODE, default 2'd0: timing mode loaded into the active-mode register at reset.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 CLK_pix_rate  input  1  pixel clock; all state SHALL update on its rising edge.
REQ-005 ce  input  1  pixel clock enable; while low, every register SHALL hold its value.
REQ-006 mode  input  2  requested timing mode (table REQ-010).
REQ-007 h_sync, v_sync  output  1 each  registered sync outputs, polarity-corrected per mode.
REQ-008 video_on  output  1  registered; high inside the active area.
REQ-009 pixel_x, pixel_y  output  COUNT_W each  registered pixel coordinates, aligned with the sync outputs and video_on.
REQ-009a line_start, frame_start  output  1 each  single-ce-cycle pulses.
REQ-009b mode_active  output  2  mode currently being generated.

Function
REQ-010 Timing table, given as display/front/sync/back, polarity:
- mode 0: H 640/16/96/48, V 480/10/2/33, negative sync.
- mode 1: H 800/40/128/88, V 600/1/4/23, positive sync.
- mode 2: H 1024/24/136/160, V 768/3/6/29, negative sync.
- mode 3 (test): H 8/2/3/1, V 4/1/1/1, negative sync.
REQ-011 Each line SHALL run display, front porch, sync, back porch in that order; H_TOT = the sum of the four H fields, and V_TOT is defined the same way.
REQ-012 On every ce cycle, h_cnt SHALL increment; at H_TOT-1 it SHALL wrap to 0.
REQ-013 v_cnt SHALL increment only when h_cnt wraps; at V_TOT-1 with h_cnt at H_TOT-1, it SHALL wrap to 0.
REQ-014 Raw h sync SHALL be asserted for h_cnt in [HD+HF, HD+HF+HS-1]; raw v sync SHALL be asserted for v_cnt in [VD+VF, VD+VF+VS-1].
REQ-015 h_sync/v_sync SHALL equal the raw sync value for positive-polarity modes and its inverse for negative-polarity modes.
REQ-016 video_on SHALL be 1 when h_cnt<HD and v_cnt<VD.
REQ-017 line_start SHALL be 1 when h_cnt==0; frame_start SHALL be 1 when h_cnt==0 and v_cnt==0.
REQ-018 All outputs SHALL be registered decodes of the counter state. They lag the counters by exactly one ce cycle, and all outputs describe the same pixel in the same cycle.
REQ-019 mode SHALL be sampled only on the ce cycle where h_cnt==H_TOT-1 and v_cnt==V_TOT-1, and loaded into mode_active. The new mode's first pixel (0,0) SHALL follow immediately with no gap cycle.
REQ-020 mode changes at any other time SHALL be ignored until the next frame end; a mode that toggles and then returns before frame end SHALL cause no change.
REQ-021 Out-of-range counter values SHALL be impossible by construction, since counters only wrap at the active mode's totals.
REQ-022 ce held low for any duration SHALL resume with no skipped or repeated pixel.

Reset
REQ-023 Reset SHALL force h_cnt=0, v_cnt=0 and mode_active=RESET_MODE.
REQ-024 Reset SHALL force these outputs: pixel_x=0, pixel_y=0, video_on=0, line_start=0, frame_start=0, and h_sync/v_sync at the inactive level of RESET_MODE (1 for negative polarity).
REQ-025 On the first ce edge after release, outputs SHALL show pixel (0,0): video_on=1, line_start=1, frame_start=1.
REQ-026 Reset asserted mid-frame SHALL take effect immediately and restart from REQ-024 with no residual state.

Structure
REQ-027 Package vga_timing_pkg SHALL hold:
- the mode enumeration;
- the per-mode H/V display/front/sync/back constants;
- polarity bits;
- helper functions returning H_TOT/V_TOT for a mode.
REQ-028 One sub-module, vga_axis_counter (parametrised width, runtime terminal count, enable, wrap pulse), SHALL be instantiated twice: once for horizontal, once for vertical.

Verification
REQ-029 Test mode 3, ce=1: frame period = 14x7 = 98 cycles. h_sync SHALL be low for exactly 3 cycles at pixel_x 10..12. v_sync SHALL be low for 14 cycles at pixel_y 5. video_on SHALL be high for 32 cycles per frame.
REQ-030 Mode 0, ce=1, run 2 frames: frame_start SHALL occur every 800x525 = 420000 cycles. h_sync SHALL be low at pixel_x 656..751; v_sync SHALL be low at pixel_y 490..491.
REQ-031 Mode 3 running; switch mode to 1 at pixel (3,2): mode_active SHALL stay 3 until the cycle after (13,6). Next pixel SHALL be (0,0) in mode 1, with h_sync now active-high at pixel_x 840..967.
REQ-032 Mode 3 with ce toggling 1-0-1 pseudo-randomly: pixel sequence SHALL be identical to the ce=1 run when sampled only on ce cycles.
REQ-033 Assert reset at pixel (500,300) in mode 0: all outputs SHALL take REQ-024 values asynchronously. First ce edge after release SHALL give (0,0) with frame_start=1.
REQ-034 Coverage SHALL include all four modes, a mode request of the same value (no effect), and COUNT_W=12 elaborated and passing REQ-029.
